// File: rtl/memory_controller.sv
// Byte-serial responder for LSB load/store and instruction-fetch requests on a shared 8-bit RAM/IO bus.
// inst_type encoding: [3]=store, [2]=unsigned load, [1:0]=size (0 byte, 1 half, 2 word).
module memory_controller #(
  parameter logic [31:0] IO_BASE = 32'h30000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback_from_rob,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        valid_from_lsb,
  input  logic [3:0]  inst_type_from_lsb,
  input  logic [31:0] addr_from_lsb,
  input  logic [31:0] data_from_lsb,
  output logic        valid_to_lsb,
  output logic [31:0] data_to_lsb,
  input  logic        valid_from_ifetch,
  input  logic [31:0] addr_from_ifetch,
  output logic        valid_to_ifetch,
  output logic [31:0] inst_to_ifetch
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_q;
  logic        owner_q;        // 0 = LSB, 1 = ifetch
  logic [2:0]  type_q;
  logic [31:0] base_q;
  logic [31:0] data_q;
  logic [2:0]  idx_q;
  logic [23:0] buf_q;
  logic        quiet_q;        // store continues after rollback but reports nothing
  logic        mem_wr_q;
  logic [31:0] mem_a_q;
  logic [7:0]  mem_dout_q;
  logic        valid_lsb_q;
  logic        valid_if_q;
  logic [31:0] data_lsb_q;
  logic [31:0] inst_q;

  logic [2:0]  len;
  logic [2:0]  idx_inc;
  logic [31:0] next_addr;
  logic [7:0]  wbyte;
  logic        io_stall;
  logic [31:0] word;
  logic [31:0] load_ext;

  assign idx_inc   = idx_q + 3'd1;
  assign next_addr = base_q + {29'b0, idx_inc};
  assign wbyte     = data_q[{idx_inc[1:0], 3'b000} +: 8];
  assign io_stall  = mem_wr_q && (mem_a_q >= IO_BASE) && io_buffer_full;

  assign mem_wr          = mem_wr_q && rdy && !io_stall;
  assign mem_a           = mem_a_q;
  assign mem_dout        = mem_dout_q;
  assign valid_to_lsb    = valid_lsb_q;
  assign data_to_lsb     = data_lsb_q;
  assign valid_to_ifetch = valid_if_q;
  assign inst_to_ifetch  = inst_q;

  always_comb begin
    case (type_q[1:0])
      2'd0:    len = 3'd1;
      2'd1:    len = 3'd2;
      default: len = 3'd4;
    endcase
  end

  // The final byte comes straight from the bus so the result is ready on the completing edge.
  always_comb begin
    word = {mem_din, buf_q};
    case (len)
      3'd1:    word = {24'b0, mem_din};
      3'd2:    word = {16'b0, mem_din, buf_q[7:0]};
      default: ;
    endcase
    load_ext = word;
    case (type_q[1:0])
      2'd0:    load_ext = type_q[2] ? {24'b0, word[7:0]} : {{24{word[7]}}, word[7:0]};
      2'd1:    load_ext = type_q[2] ? {16'b0, word[15:0]} : {{16{word[15]}}, word[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      type_q      <= '0;
      base_q      <= '0;
      data_q      <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
      quiet_q     <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      valid_lsb_q <= 1'b0;
      valid_if_q  <= 1'b0;
      data_lsb_q  <= '0;
      inst_q      <= '0;
    end else if (rdy) begin
      if (rollback_from_rob && state_q != WRITE) begin
        state_q     <= IDLE;
        idx_q       <= '0;
        quiet_q     <= 1'b0;
        mem_wr_q    <= 1'b0;
        mem_a_q     <= '0;
        mem_dout_q  <= '0;
        valid_lsb_q <= 1'b0;
        valid_if_q  <= 1'b0;
        data_lsb_q  <= '0;
        inst_q      <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            quiet_q <= 1'b0;
            if (valid_from_lsb || valid_from_ifetch) begin
              owner_q <= !valid_from_lsb;
              type_q  <= valid_from_lsb ? inst_type_from_lsb[2:0] : 3'b010;
              base_q  <= valid_from_lsb ? addr_from_lsb : addr_from_ifetch;
              mem_a_q <= valid_from_lsb ? addr_from_lsb : addr_from_ifetch;
              data_q  <= data_from_lsb;
              idx_q   <= '0;
              if (valid_from_lsb && inst_type_from_lsb[3]) begin
                mem_wr_q   <= 1'b1;
                mem_dout_q <= data_from_lsb[7:0];
                state_q    <= WRITE;
              end else begin
                mem_wr_q <= 1'b0;
                state_q  <= READ;
              end
            end
          end
          READ: begin
            if (idx_q == len) begin
              state_q <= DONE;
              mem_a_q <= '0;
              if (owner_q) begin
                valid_if_q <= 1'b1;
                inst_q     <= word;
              end else begin
                valid_lsb_q <= 1'b1;
                data_lsb_q  <= load_ext;
              end
            end else begin
              mem_a_q <= next_addr;
              idx_q   <= idx_inc;
              case (idx_q)
                3'd1:    buf_q[7:0]   <= mem_din;
                3'd2:    buf_q[15:8]  <= mem_din;
                3'd3:    buf_q[23:16] <= mem_din;
                default: ;
              endcase
            end
          end
          WRITE: begin
            if (rollback_from_rob) quiet_q <= 1'b1;
            // One idle cycle after the last byte keeps write latency equal to read latency.
            if (!mem_wr_q) begin
              state_q    <= DONE;
              mem_a_q    <= '0;
              mem_dout_q <= '0;
              if (!(quiet_q || rollback_from_rob)) begin
                valid_lsb_q <= 1'b1;
                data_lsb_q  <= '0;
              end
            end else if (!io_stall) begin
              if (idx_q == len - 3'd1) begin
                mem_wr_q <= 1'b0;
              end else begin
                idx_q      <= idx_inc;
                mem_a_q    <= next_addr;
                mem_dout_q <= wbyte;
              end
            end
          end
          DONE: begin
            valid_lsb_q <= 1'b0;
            valid_if_q  <= 1'b0;
            quiet_q     <= 1'b0;
            state_q     <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: byte RAM + IO write log model, hand-computed expectations.
module tb_memory_controller;
  localparam logic [31:0] IO_BASE = 32'h30000;
  localparam logic [3:0] LB = 4'd0, LH = 4'd1, LW = 4'd2, LBU = 4'd4, LHU = 4'd5;
  localparam logic [3:0] SB = 4'd8, SH = 4'd9, SW = 4'd10;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback_from_rob, io_buffer_full;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        valid_from_lsb;
  logic [3:0]  inst_type_from_lsb;
  logic [31:0] addr_from_lsb, data_from_lsb;
  logic        valid_to_lsb;
  logic [31:0] data_to_lsb;
  logic        valid_from_ifetch;
  logic [31:0] addr_from_ifetch;
  logic        valid_to_ifetch;
  logic [31:0] inst_to_ifetch;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  memory_controller #(.IO_BASE(IO_BASE)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback_from_rob(rollback_from_rob),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .valid_from_lsb(valid_from_lsb),
    .inst_type_from_lsb(inst_type_from_lsb), .addr_from_lsb(addr_from_lsb),
    .data_from_lsb(data_from_lsb), .valid_to_lsb(valid_to_lsb), .data_to_lsb(data_to_lsb),
    .valid_from_ifetch(valid_from_ifetch), .addr_from_ifetch(addr_from_ifetch),
    .valid_to_ifetch(valid_to_ifetch), .inst_to_ifetch(inst_to_ifetch)
  );

  // RAM with one-cycle read latency; every bus write (RAM or IO) is logged.
  logic [7:0]  ram [0:4095];
  logic        poke_en = 1'b0;
  logic [11:0] poke_a = '0;
  logic [7:0]  poke_d = '0;
  logic [31:0] wlog_a [0:63];
  logic [7:0]  wlog_d [0:63];
  int          wcnt = 0;

  always @(posedge clk) begin
    if (mem_wr) begin
      if (wcnt < 64) begin
        wlog_a[wcnt] <= mem_a;
        wlog_d[wcnt] <= mem_dout;
      end
      wcnt <= wcnt + 1;
      if (mem_a < IO_BASE) ram[mem_a[11:0]] <= mem_dout;
    end else if (poke_en) begin
      ram[poke_a] <= poke_d;
    end
    mem_din <= ram[mem_a[11:0]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("vec %0d %s: observed %h expected %h", vectors, tag, obs, exp);
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    poke_en = 1'b1;
    poke_a  = a;
    poke_d  = d;
    step();
    poke_en = 1'b0;
  endtask

  // Issue one LSB request; lat = edges after the accepting edge until the pulse is seen.
  task automatic lsb_op(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] res);
    valid_from_lsb     = 1'b1;
    inst_type_from_lsb = t;
    addr_from_lsb      = a;
    data_from_lsb      = d;
    lat = -1;
    do begin
      step();
      lat++;
    end while (!valid_to_lsb && lat < 30);
    res = data_to_lsb;
    valid_from_lsb = 1'b0;
    step();
    chk("single_pulse", 32'(valid_to_lsb), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int base;
    int pulses;
    logic [31:0] res;

    rst = 1'b1; rdy = 1'b1; rollback_from_rob = 1'b0; io_buffer_full = 1'b0;
    valid_from_lsb = 1'b0; inst_type_from_lsb = '0; addr_from_lsb = '0; data_from_lsb = '0;
    valid_from_ifetch = 1'b0; addr_from_ifetch = '0;

    poke(12'h100, 8'h11); poke(12'h101, 8'h22); poke(12'h102, 8'h33); poke(12'h103, 8'h44);
    poke(12'h020, 8'h80); poke(12'h021, 8'h92); poke(12'h042, 8'h5A);
    poke(12'h000, 8'h78); poke(12'h001, 8'h56); poke(12'h002, 8'h34); poke(12'h003, 8'h12);

    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    chk("rst_valid_lsb", 32'(valid_to_lsb), 32'd0);
    chk("rst_valid_if", 32'(valid_to_ifetch), 32'd0);
    chk("rst_data_lsb", data_to_lsb, 32'd0);
    chk("rst_inst", inst_to_ifetch, 32'd0);
    rst = 1'b0;
    step();

    lsb_op(LW, 32'h100, 32'd0, lat, res);
    chk("lw_latency", 32'(lat), 32'd5);
    chk("lw_data", res, 32'h44332211);

    lsb_op(LB, 32'h20, 32'd0, lat, res);
    chk("lb_latency", 32'(lat), 32'd2);
    chk("lb_data", res, 32'hFFFFFF80);
    lsb_op(LBU, 32'h20, 32'd0, lat, res);
    chk("lbu_data", res, 32'h00000080);
    poke(12'h020, 8'h34);
    lsb_op(LH, 32'h20, 32'd0, lat, res);
    chk("lh_latency", 32'(lat), 32'd3);
    chk("lh_data", res, 32'hFFFF9234);
    lsb_op(LHU, 32'h20, 32'd0, lat, res);
    chk("lhu_data", res, 32'h00009234);

    base = wcnt;
    lsb_op(SH, 32'h40, 32'hDEADBEEF, lat, res);
    chk("sh_latency", 32'(lat), 32'd3);
    chk("sh_data_zero", res, 32'd0);
    chk("sh_write_count", 32'(wcnt - base), 32'd2);
    chk("sh_w0_addr", wlog_a[base], 32'h40);
    chk("sh_w0_data", 32'(wlog_d[base]), 32'hEF);
    chk("sh_w1_addr", wlog_a[base + 1], 32'h41);
    chk("sh_w1_data", 32'(wlog_d[base + 1]), 32'hBE);
    chk("sh_ram42_untouched", 32'(ram[12'h042]), 32'h5A);

    valid_from_lsb = 1'b1; inst_type_from_lsb = LW; addr_from_lsb = 32'h100;
    valid_from_ifetch = 1'b1; addr_from_ifetch = 32'h0;
    lat = -1;
    do begin
      step();
      lat++;
    end while (!valid_to_lsb && lat < 30);
    chk("prio_lsb_latency", 32'(lat), 32'd5);
    chk("prio_lsb_data", data_to_lsb, 32'h44332211);
    chk("prio_no_ifetch_yet", 32'(valid_to_ifetch), 32'd0);
    valid_from_lsb = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!valid_to_ifetch && lat < 30);
    chk("ifetch_after_done", 32'(lat), 32'd7);
    chk("ifetch_inst", inst_to_ifetch, 32'h12345678);
    valid_from_ifetch = 1'b0;
    step();
    chk("ifetch_single_pulse", 32'(valid_to_ifetch), 32'd0);

    valid_from_ifetch = 1'b1; addr_from_ifetch = 32'h0;
    step(); step(); step();
    chk("rb_fetch_idx2_addr", mem_a, 32'h2);
    rollback_from_rob = 1'b1;
    valid_from_ifetch = 1'b0;
    step();
    rollback_from_rob = 1'b0;
    chk("rb_fetch_mem_a", mem_a, 32'd0);
    chk("rb_fetch_inst", inst_to_ifetch, 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (valid_to_ifetch) pulses++;
      step();
    end
    chk("rb_fetch_no_pulse", 32'(pulses), 32'd0);
    lsb_op(LB, 32'h20, 32'd0, lat, res);
    chk("rb_then_lb_latency", 32'(lat), 32'd2);
    chk("rb_then_lb_data", res, 32'h00000034);

    base = wcnt;
    valid_from_lsb = 1'b1; inst_type_from_lsb = SW; addr_from_lsb = 32'h60;
    data_from_lsb = 32'hA1B2C3D4;
    step(); step();
    rollback_from_rob = 1'b1;
    valid_from_lsb = 1'b0;
    step();
    rollback_from_rob = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (valid_to_lsb) pulses++;
      step();
    end
    chk("rb_sw_no_pulse", 32'(pulses), 32'd0);
    chk("rb_sw_write_count", 32'(wcnt - base), 32'd4);
    chk("rb_sw_ram", {ram[12'h063], ram[12'h062], ram[12'h061], ram[12'h060]}, 32'hA1B2C3D4);

    base = wcnt;
    io_buffer_full = 1'b1;
    valid_from_lsb = 1'b1; inst_type_from_lsb = SB; addr_from_lsb = IO_BASE;
    data_from_lsb = 32'h00000041;
    step();
    chk("io_stall_wr_c0", 32'(mem_wr), 32'd0);
    step();
    chk("io_stall_wr_c1", 32'(mem_wr), 32'd0);
    step();
    chk("io_stall_wr_c2", 32'(mem_wr), 32'd0);
    step();
    io_buffer_full = 1'b0;
    #1;
    chk("io_resume_wr", 32'(mem_wr), 32'd1);
    lat = 3;
    do begin
      step();
      lat++;
    end while (!valid_to_lsb && lat < 30);
    valid_from_lsb = 1'b0;
    chk("io_latency", 32'(lat), 32'd5);
    chk("io_write_count", 32'(wcnt - base), 32'd1);
    chk("io_write_addr", wlog_a[base], IO_BASE);
    chk("io_write_data", 32'(wlog_d[base]), 32'h41);
    step();
    chk("io_single_pulse", 32'(valid_to_lsb), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
